jtkcpu_busctrl: RTL and testbench
=================================

Name: jtkcpu_busctrl

Overview:
Parametrised bus controller between the JTKCPU control unit and the external byte-wide memory bus. It runs multi-byte big-endian read and write transfers of 1 to MAXB bytes from a selected address source, stalls on bus wait states, and fetches interrupt vectors. It sits between the control unit/ALU and the system bus.

Parameters:
AW, 16, address bus width in bits; all address arithmetic is modulo 2^AW
MAXB, 4, maximum bytes per transfer (2..4); sets the rdata/wdata width
VECBASE, 16'hFFF6, vector table base; IRQ=+2, FIRQ=+0, NMI=+6, RST=+8 (all truncated to AW)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cen  in  1  clock enable; all state advances only when cen=1
req  in  1  transfer request, level; sampled in IDLE only
wr  in  1  1=write, 0=read; sampled with req
len  in  2  bytes-1 (0..MAXB-1); values >=MAXB saturate to MAXB-1
asel  in  3  address source: 0=pc, 1=psh_addr, 2=idx_addr, 3=regs_x, 4=regs_y, 5={dp,opl}; 6,7 map to pc
pc, psh_addr, idx_addr, regs_x, regs_y  in  AW each  address candidates
dp  in  8  direct page register
opl  in  8  direct-mode offset byte
wdata  in  8*MAXB  write data, right-aligned, sent MSB first
intvec  in  4  one-hot interrupt request: b0=IRQ, b1=FIRQ, b2=NMI, b3=RST
bus_ok  in  1  0 = wait state; the current byte is held
din  in  8  read data
addr  out  AW  bus address
dout  out  8  write data
we  out  1  write strobe
rdata  out  8*MAXB  assembled read data, right-aligned
is_op  out  1  current transfer is an opcode fetch (asel=0, read, len=0)
busy  out  1  high from request acceptance until ack/vec_done
ack  out  1  one-cen pulse: transfer complete
vec_done  out  1  one-cen pulse: rdata[15:0] holds the vector and is loaded into the new PC

Behaviour:
- Reset values: addr=0, dout=0, we=0, rdata=0, is_op=0, busy=0, ack=0, vec_done=0; FSM state IDLE.
- FSM states: IDLE, XFER, VEC.
- Only the first cen of a transfer or vector fetch, i.e. when leaving IDLE, may latch a new address.
- IDLE:
  - If intvec!=0 on a cen: go to VEC. Priority RST>NMI>FIRQ>IRQ. addr=vector, cnt=1, busy=1.
  - Else if req on a cen: go to XFER. addr=selected source, cnt=len, wr latched, wdata latched. busy=1. If wr, then we=1 and dout=the MSB byte of the transfer, wdata[8*len+7 -: 8].
- XFER, on each cen with bus_ok=1:
  - Read: rdata = {rdata<<8 | din}. Clear rdata at entry.
  - Write: the byte on dout has completed.
  - If cnt=0: return to IDLE, we=0, busy=0, ack=1.
  - Else: cnt--, addr++ (wraps at 2^AW), and dout takes the next lower byte.
- XFER, on each cen with bus_ok=0: addr, dout, we and cnt are held; no capture.
- VEC: two reads, same rules as XFER. At completion: vec_done=1 (not ack), busy=0.
- ack and vec_done are high for exactly one cen period. With cen=1 constantly, an n-byte transfer without waits has latency n+1 clk from the accept edge to ack.
- Back-to-back: req held high in the ack cycle is accepted on the next cen in IDLE.
- req arriving while busy is ignored. The control unit holds req until it sees ack.
- Simultaneous events:
  - intvec and req together in IDLE: the vector fetch wins, req remains pending, ack is not given.
  - intvec changing during XFER/VEC is ignored.
- Reset mid-operation: the transfer is aborted immediately, we drops asynchronously, and no ack is given.
- cen=0: every register is frozen, including pulse outputs, which therefore stretch.

Decomposition:
- Package jtkcpu_bus_pkg holds:
  - asel encodings (ASEL_PC..ASEL_DP)
  - FSM state encodings
  - vector offsets
  - intvec bit positions
- Natural sub-module: jtkcpu_busctrl_amux, a combinational address source mux plus vector priority encoder. Everything else stays in one module.

Test Plan:
1. Opcode fetch: pc=16'h1234, asel=0, len=0, din=8'h86 -> addr=1234, is_op=1, rdata[7:0]=86, ack after 2 clk.
2. 16-bit read: asel=3, regs_x=16'hFFFF, din=12 then 34 -> addr goes FFFF then 0000 (wrap), rdata[15:0]=1234, ack once.
3. 4-byte write with wait: wdata=32'hDEADBEEF, asel=1, psh_addr=0100, bus_ok low for 3 clk on the second byte -> dout sequence DE,AD,BE,EF at 0100..0103, AD/0101 held for 3 extra clk, we high throughout, ack after 8 clk.
4. Interrupt priority: intvec=4'b0101 together with req -> addr=FFFC then FFFD, din=C0,00 -> vec_done with rdata[15:0]=C000, no ack; req served afterwards.
5. Reset mid-write: rst asserted during byte 2 of a 3-byte write -> we=0 and busy=0 immediately, no ack; first request after release works normally.
6. Direct mode with cen toggling every other clk: dp=8'h20, opl=8'h44, asel=5 -> addr=2044, state changes only on cen clocks, ack width = 1 cen period (2 clk).

Source files
------------

// File: rtl/jtkcpu_bus_pkg.sv
// Shared encodings for the JTKCPU bus controller: address sources, FSM states,
// interrupt vector offsets and intvec bit positions.
package jtkcpu_bus_pkg;

  localparam logic [2:0] ASEL_PC  = 3'd0;
  localparam logic [2:0] ASEL_PSH = 3'd1;
  localparam logic [2:0] ASEL_IDX = 3'd2;
  localparam logic [2:0] ASEL_X   = 3'd3;
  localparam logic [2:0] ASEL_Y   = 3'd4;
  localparam logic [2:0] ASEL_DP  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StVec
  } bus_st_e;

  localparam logic [15:0] VOFF_FIRQ = 16'd0;
  localparam logic [15:0] VOFF_IRQ  = 16'd2;
  localparam logic [15:0] VOFF_NMI  = 16'd6;
  localparam logic [15:0] VOFF_RST  = 16'd8;

  localparam int unsigned IV_IRQ  = 0;
  localparam int unsigned IV_FIRQ = 1;
  localparam int unsigned IV_NMI  = 2;
  localparam int unsigned IV_RST  = 3;

endpackage

// File: rtl/jtkcpu_busctrl_amux.sv
// Combinational address source selector and interrupt vector priority encoder.
module jtkcpu_busctrl_amux
  import jtkcpu_bus_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter logic [15:0] VECBASE = 16'hFFF6
) (
  input  logic [2:0]    asel,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] psh_addr,
  input  logic [AW-1:0] idx_addr,
  input  logic [AW-1:0] regs_x,
  input  logic [AW-1:0] regs_y,
  input  logic [7:0]    dp,
  input  logic [7:0]    opl,
  input  logic [3:0]    intvec,
  output logic [AW-1:0] src_addr,
  output logic [AW-1:0] vec_addr
);

  logic [15:0] dir_addr;
  logic [15:0] voff;
  logic [15:0] vsum;

  assign dir_addr = {dp, opl};

  always_comb begin
    src_addr = pc;
    case (asel)
      ASEL_PSH: src_addr = psh_addr;
      ASEL_IDX: src_addr = idx_addr;
      ASEL_X:   src_addr = regs_x;
      ASEL_Y:   src_addr = regs_y;
      ASEL_DP:  src_addr = AW'(dir_addr);
      default:  src_addr = pc;
    endcase
  end

  // RST > NMI > FIRQ > IRQ; the result is unused when intvec is zero
  always_comb begin
    voff = VOFF_IRQ;
    if (intvec[IV_RST]) begin
      voff = VOFF_RST;
    end else if (intvec[IV_NMI]) begin
      voff = VOFF_NMI;
    end else if (intvec[IV_FIRQ]) begin
      voff = VOFF_FIRQ;
    end
    vsum     = VECBASE + voff;
    vec_addr = AW'(vsum);
  end

endmodule

// File: rtl/jtkcpu_busctrl.sv
// JTKCPU bus controller: big-endian multi-byte read/write transfers on a byte-wide
// bus with wait states, plus two-byte interrupt vector fetches.
module jtkcpu_busctrl
  import jtkcpu_bus_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned MAXB    = 4,
  parameter logic [15:0] VECBASE = 16'hFFF6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        len,
  input  logic [2:0]        asel,
  input  logic [AW-1:0]     pc,
  input  logic [AW-1:0]     psh_addr,
  input  logic [AW-1:0]     idx_addr,
  input  logic [AW-1:0]     regs_x,
  input  logic [AW-1:0]     regs_y,
  input  logic [7:0]        dp,
  input  logic [7:0]        opl,
  input  logic [8*MAXB-1:0] wdata,
  input  logic [3:0]        intvec,
  input  logic              bus_ok,
  input  logic [7:0]        din,
  output logic [AW-1:0]     addr,
  output logic [7:0]        dout,
  output logic              we,
  output logic [8*MAXB-1:0] rdata,
  output logic              is_op,
  output logic              busy,
  output logic              ack,
  output logic              vec_done
);

  localparam int unsigned DW = 8 * MAXB;

  logic [AW-1:0] src_addr, vec_addr;
  logic [1:0]    len_sat;

  bus_st_e       st_q, st_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          we_q, we_d;
  logic          is_op_q, is_op_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic          vec_done_q, vec_done_d;

  jtkcpu_busctrl_amux #(
    .AW      (AW),
    .VECBASE (VECBASE)
  ) u_amux (
    .asel     (asel),
    .pc       (pc),
    .psh_addr (psh_addr),
    .idx_addr (idx_addr),
    .regs_x   (regs_x),
    .regs_y   (regs_y),
    .dp       (dp),
    .opl      (opl),
    .intvec   (intvec),
    .src_addr (src_addr),
    .vec_addr (vec_addr)
  );

  assign len_sat = (32'(len) >= MAXB) ? 2'(MAXB - 1) : len;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    we_d       = we_q;
    is_op_d    = is_op_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    vec_done_d = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (|intvec) begin
          st_d    = StVec;
          addr_d  = vec_addr;
          cnt_d   = 2'd1;
          wr_d    = 1'b0;
          we_d    = 1'b0;
          rdata_d = '0;
          is_op_d = 1'b0;
          busy_d  = 1'b1;
        end else if (req) begin
          st_d    = StXfer;
          addr_d  = src_addr;
          cnt_d   = len_sat;
          wr_d    = wr;
          wdata_d = wdata;
          rdata_d = '0;
          we_d    = wr;
          is_op_d = (asel == ASEL_PC) && !wr && (len_sat == 2'd0);
          busy_d  = 1'b1;
          if (wr) dout_d = wdata[{len_sat, 3'b000} +: 8];
        end
      end
      StXfer, StVec: begin
        // bus_ok low is a wait state: every bus-facing register holds
        if (bus_ok) begin
          if (!wr_q) rdata_d = {rdata_q[DW-9:0], din};
          if (cnt_q == 2'd0) begin
            st_d       = StIdle;
            we_d       = 1'b0;
            busy_d     = 1'b0;
            ack_d      = (st_q == StXfer);
            vec_done_d = (st_q == StVec);
          end else begin
            cnt_d  = cnt_q - 2'd1;
            addr_d = addr_q + AW'(1);
            dout_d = wdata_q[{cnt_q - 2'd1, 3'b000} +: 8];
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= StIdle;
      cnt_q      <= 2'd0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dout_q     <= 8'd0;
      we_q       <= 1'b0;
      is_op_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      vec_done_q <= 1'b0;
    end else if (cen) begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      we_q       <= we_d;
      is_op_q    <= is_op_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      vec_done_q <= vec_done_d;
    end
  end

  assign addr     = addr_q;
  assign dout     = dout_q;
  assign we       = we_q;
  assign rdata    = rdata_q;
  assign is_op    = is_op_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign vec_done = vec_done_q;

endmodule

// File: tb/tb_jtkcpu_busctrl.sv
// Scoreboard bench for jtkcpu_busctrl: expected bus bytes and completions are queued
// as stimulus is driven and checked by negedge monitors.
module tb_jtkcpu_busctrl;

  logic        clk, rst, cen, req, wr, bus_ok;
  logic [1:0]  len;
  logic [2:0]  asel;
  logic [15:0] pc, psh_addr, idx_addr, regs_x, regs_y;
  logic [7:0]  dp, opl, din, dout;
  logic [31:0] wdata, rdata;
  logic [3:0]  intvec;
  logic [15:0] addr;
  logic        we, is_op, busy, ack, vec_done;

  logic [7:0]  mem [0:65535];
  assign din = mem[addr];

  jtkcpu_busctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .req      (req),
    .wr       (wr),
    .len      (len),
    .asel     (asel),
    .pc       (pc),
    .psh_addr (psh_addr),
    .idx_addr (idx_addr),
    .regs_x   (regs_x),
    .regs_y   (regs_y),
    .dp       (dp),
    .opl      (opl),
    .wdata    (wdata),
    .intvec   (intvec),
    .bus_ok   (bus_ok),
    .din      (din),
    .addr     (addr),
    .dout     (dout),
    .we       (we),
    .rdata    (rdata),
    .is_op    (is_op),
    .busy     (busy),
    .ack      (ack),
    .vec_done (vec_done)
  );

  typedef struct packed {
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
  } byte_t;

  typedef struct packed {
    logic        is_vec;
    logic [31:0] data;
    logic [31:0] mask;
  } done_t;

  byte_t byte_q[$];
  done_t done_q[$];
  byte_t mon_b;
  done_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  logic cen_tog = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cen_tog) cen = ~cen;
  endtask

  task automatic start_req(input logic [2:0] a, input logic [1:0] l, input logic w,
                           input logic [31:0] wd);
    int n;
    asel  = a;
    len   = l;
    wr    = w;
    wdata = wd;
    req   = 1'b1;
    n     = 0;
    do begin
      tick();
      n++;
    end while (!busy && n < 16);
    if (!busy) check("accept_timeout", 32'd0, 32'd1);
    req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(ack || vec_done) && n < 64) begin
      tick();
      n++;
    end
    if (!(ack || vec_done)) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitors look at the values the coming active edge will commit
  always @(negedge clk) begin
    if (!rst && cen) begin
      if (busy && bus_ok) begin
        if (byte_q.size() == 0) begin
          check("extra_byte", 32'd1, 32'd0);
        end else begin
          mon_b = byte_q.pop_front();
          check("byte_addr", {16'd0, addr}, {16'd0, mon_b.a});
          check("byte_we", {31'd0, we}, {31'd0, mon_b.w});
          if (mon_b.w) check("byte_dout", {24'd0, dout}, {24'd0, mon_b.d});
        end
      end
      if (ack || vec_done) begin
        if (done_q.size() == 0) begin
          check("extra_done", 32'd1, 32'd0);
        end else begin
          mon_e = done_q.pop_front();
          check("done_vec", {31'd0, vec_done}, {31'd0, mon_e.is_vec});
          check("done_ack", {31'd0, ack}, {31'd0, !mon_e.is_vec});
          check("done_rdata", rdata & mon_e.mask, mon_e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cen = 1'b1; req = 1'b0; wr = 1'b0; bus_ok = 1'b1;
    len = 2'd0; asel = 3'd0; wdata = 32'd0; intvec = 4'd0;
    pc = 16'h1234; psh_addr = 16'h0100; idx_addr = 16'h0300;
    regs_x = 16'hFFFF; regs_y = 16'h4000; dp = 8'h20; opl = 8'h44;
    mem[16'h1234] = 8'h86; mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
    mem[16'hFFFC] = 8'hC0; mem[16'hFFFD] = 8'h00; mem[16'h2000] = 8'h55;
    mem[16'h2044] = 8'h5A;

    repeat (2) tick();
    check("rst_addr", {16'd0, addr}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_isop", {31'd0, is_op}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_vecdone", {31'd0, vec_done}, 32'd0);
    rst = 1'b0;
    tick();

    // Opcode fetch
    byte_q.push_back('{a: 16'h1234, w: 1'b0, d: 8'h00});
    done_q.push_back('{is_vec: 1'b0, data: 32'h86, mask: 32'hFF});
    t0 = cyc;
    start_req(3'd0, 2'd0, 1'b0, 32'd0);
    check("t1_addr", {16'd0, addr}, 32'h1234);
    check("t1_isop", {31'd0, is_op}, 32'd1);
    wait_done();
    check("t1_lat", cyc - t0, 32'd2);
    check("t1_busy_at_ack", {31'd0, busy}, 32'd0);
    tick();
    check("t1_ack_once", {31'd0, ack}, 32'd0);

    // 16-bit read through regs_x, address wraps
    byte_q.push_back('{a: 16'hFFFF, w: 1'b0, d: 8'h00});
    byte_q.push_back('{a: 16'h0000, w: 1'b0, d: 8'h00});
    done_q.push_back('{is_vec: 1'b0, data: 32'h1234, mask: 32'hFFFF});
    t0 = cyc;
    start_req(3'd3, 2'd1, 1'b0, 32'd0);
    check("t2_addr0", {16'd0, addr}, 32'hFFFF);
    check("t2_isop", {31'd0, is_op}, 32'd0);
    tick();
    check("t2_addr1", {16'd0, addr}, 32'h0000);
    wait_done();
    check("t2_lat", cyc - t0, 32'd3);
    tick();

    // 4-byte write with three wait states on byte 2
    byte_q.push_back('{a: 16'h0100, w: 1'b1, d: 8'hDE});
    byte_q.push_back('{a: 16'h0101, w: 1'b1, d: 8'hAD});
    byte_q.push_back('{a: 16'h0102, w: 1'b1, d: 8'hBE});
    byte_q.push_back('{a: 16'h0103, w: 1'b1, d: 8'hEF});
    done_q.push_back('{is_vec: 1'b0, data: 32'd0, mask: 32'd0});
    t0 = cyc;
    start_req(3'd1, 2'd3, 1'b1, 32'hDEADBEEF);
    check("t3_dout0", {24'd0, dout}, 32'hDE);
    check("t3_we0", {31'd0, we}, 32'd1);
    tick();
    bus_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_addr", {16'd0, addr}, 32'h0101);
      check("t3_hold_dout", {24'd0, dout}, 32'hAD);
      check("t3_hold_we", {31'd0, we}, 32'd1);
    end
    bus_ok = 1'b1;
    wait_done();
    check("t3_lat", cyc - t0, 32'd8);
    check("t3_we_end", {31'd0, we}, 32'd0);
    tick();

    // NMI+IRQ together with a request: NMI vector first, request afterwards
    byte_q.push_back('{a: 16'hFFFC, w: 1'b0, d: 8'h00});
    byte_q.push_back('{a: 16'hFFFD, w: 1'b0, d: 8'h00});
    byte_q.push_back('{a: 16'h2000, w: 1'b0, d: 8'h00});
    done_q.push_back('{is_vec: 1'b1, data: 32'hC000, mask: 32'hFFFF});
    done_q.push_back('{is_vec: 1'b0, data: 32'h55, mask: 32'hFF});
    pc = 16'h2000; asel = 3'd0; len = 2'd0; wr = 1'b0; req = 1'b1;
    intvec = 4'b0101;
    tick();
    check("t4_busy", {31'd0, busy}, 32'd1);
    check("t4_addr0", {16'd0, addr}, 32'hFFFC);
    intvec = 4'b1000;
    tick();
    check("t4_addr1", {16'd0, addr}, 32'hFFFD);
    intvec = 4'b0000;
    wait_done();
    check("t4_vecdone", {31'd0, vec_done}, 32'd1);
    check("t4_noack", {31'd0, ack}, 32'd0);
    check("t4_vector", rdata & 32'hFFFF, 32'hC000);
    tick();
    check("t4_req_busy", {31'd0, busy}, 32'd1);
    check("t4_req_addr", {16'd0, addr}, 32'h2000);
    req = 1'b0;
    wait_done();
    check("t4_req_ack", {31'd0, ack}, 32'd1);
    tick();

    // Reset in the middle of a 3-byte write
    byte_q.push_back('{a: 16'h0300, w: 1'b1, d: 8'hA1});
    byte_q.push_back('{a: 16'h0301, w: 1'b1, d: 8'hB2});
    byte_q.push_back('{a: 16'h0302, w: 1'b1, d: 8'hC3});
    done_q.push_back('{is_vec: 1'b0, data: 32'd0, mask: 32'd0});
    start_req(3'd2, 2'd2, 1'b1, 32'h00A1B2C3);
    check("t5_dout0", {24'd0, dout}, 32'hA1);
    tick();
    check("t5_addr1", {16'd0, addr}, 32'h0301);
    bus_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_we_async", {31'd0, we}, 32'd0);
    check("t5_busy_async", {31'd0, busy}, 32'd0);
    check("t5_addr_async", {16'd0, addr}, 32'd0);
    check("t5_bytes_left", byte_q.size(), 32'd2);
    check("t5_no_ack", done_q.size(), 32'd1);
    byte_q.delete();
    done_q.delete();
    tick();
    tick();
    check("t5_ack_in_rst", {31'd0, ack}, 32'd0);
    bus_ok = 1'b1;
    rst = 1'b0;
    tick();
    pc = 16'h1234;
    byte_q.push_back('{a: 16'h1234, w: 1'b0, d: 8'h00});
    done_q.push_back('{is_vec: 1'b0, data: 32'h86, mask: 32'hFF});
    t0 = cyc;
    start_req(3'd0, 2'd0, 1'b0, 32'd0);
    wait_done();
    check("t5_after_lat", cyc - t0, 32'd2);
    tick();

    // Direct mode with cen on every other clk
    byte_q.push_back('{a: 16'h2044, w: 1'b0, d: 8'h00});
    done_q.push_back('{is_vec: 1'b0, data: 32'h5A, mask: 32'hFF});
    cen_tog = 1'b1;
    start_req(3'd5, 2'd0, 1'b0, 32'd0);
    check("t6_addr", {16'd0, addr}, 32'h2044);
    tick();
    check("t6_frozen_busy", {31'd0, busy}, 32'd1);
    check("t6_frozen_ack", {31'd0, ack}, 32'd0);
    wait_done();
    check("t6_ack", {31'd0, ack}, 32'd1);
    tick();
    check("t6_ack_stretch", {31'd0, ack}, 32'd1);
    tick();
    check("t6_ack_end", {31'd0, ack}, 32'd0);
    cen_tog = 1'b0;
    cen = 1'b1;

    repeat (3) tick();
    check("sb_bytes_empty", byte_q.size(), 32'd0);
    check("sb_done_empty", done_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
